uart_cmd_decoder: RTL and testbench

Receive-side counterpart to the board-state UART transmit path. Consumes bytes from uart_top (o_rx_data/o_rx_valid) and decodes terminal keystrokes into game commands: WASD, hjkl, ANSI arrow escape sequences (ESC '[' A..D), new-game and difficulty keys. Moves are buffered in a small FIFO and issued to game_logic one at a time as single-cycle button-equivalent pulses. The next move is issued only after game_logic acknowledges the previous one or a timeout expires.

---
 rtl/uart_cmd_decoder.sv | 215 +++++++++++++++++++++
 tb/tb_uart_cmd_decoder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_decoder.sv
// Decodes UART keystrokes (WASD, hjkl, ANSI arrows, new-game, difficulty) into
// game commands; moves are queued and issued one at a time, gated by i_ack.
module uart_cmd_decoder #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ESC_TMO    = 100000,
  parameter int unsigned ACK_TMO    = 20000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_valid,
  input  logic       i_ack,
  output logic       o_btnL,
  output logic       o_btnR,
  output logic       o_btnU,
  output logic       o_btnD,
  output logic       o_valid,
  output logic       o_new_game,
  output logic [1:0] o_diff,
  output logic       o_err
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ESC_W = $clog2(ESC_TMO + 1);
  localparam int unsigned ACK_W = $clog2(ACK_TMO + 1);

  localparam logic [1:0] P_IDLE  = 2'd0;
  localparam logic [1:0] P_ESC   = 2'd1;
  localparam logic [1:0] P_CSI   = 2'd2;
  localparam logic [0:0] I_READY = 1'b0;
  localparam logic [0:0] I_WAIT  = 1'b1;

  localparam logic [1:0] MV_L = 2'b00;
  localparam logic [1:0] MV_R = 2'b01;
  localparam logic [1:0] MV_U = 2'b10;
  localparam logic [1:0] MV_D = 2'b11;

  logic [1:0]       p_state_q, p_state_d;
  logic [ESC_W-1:0] esc_cnt_q, esc_cnt_d;
  logic [0:0]       i_state_q, i_state_d;
  logic [ACK_W-1:0] ack_cnt_q, ack_cnt_d;
  logic [1:0]       mem_q [FIFO_DEPTH];
  logic [1:0]       mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [3:0]       btn_q, btn_d;
  logic             valid_q, valid_d;
  logic             new_game_q, new_game_d;
  logic [1:0]       diff_q, diff_d;
  logic             err_q, err_d;

  logic       move_vld, new_game, dec_err, pop, push, overflow, ack_tmo;
  logic [1:0] move_code;
  logic [CNT_W-1:0] count_after_pop;

  // Byte parser: plain keys, ESC '[' x arrow sequences, escape timeout
  always_comb begin
    p_state_d = p_state_q;
    esc_cnt_d = esc_cnt_q;
    move_vld  = 1'b0;
    move_code = MV_L;
    new_game  = 1'b0;
    dec_err   = 1'b0;
    diff_d    = diff_q;
    if (i_rx_valid) begin
      esc_cnt_d = '0;
      case (p_state_q)
        P_IDLE: begin
          case (i_rx_data)
            8'h77, 8'h57, 8'h6B: begin move_vld = 1'b1; move_code = MV_U; end
            8'h73, 8'h53, 8'h6A: begin move_vld = 1'b1; move_code = MV_D; end
            8'h61, 8'h41, 8'h68: begin move_vld = 1'b1; move_code = MV_L; end
            8'h64, 8'h44, 8'h6C: begin move_vld = 1'b1; move_code = MV_R; end
            8'h6E, 8'h4E:        new_game = 1'b1;
            8'h30, 8'h31, 8'h32, 8'h33: diff_d = i_rx_data[1:0];
            8'h1B:               p_state_d = P_ESC;
            8'h0D, 8'h0A, 8'h20: ;
            default:             dec_err = 1'b1;
          endcase
        end
        P_ESC: begin
          if (i_rx_data == 8'h5B) begin
            p_state_d = P_CSI;
          end else if (i_rx_data != 8'h1B) begin
            p_state_d = P_IDLE;
            dec_err   = 1'b1;
          end
        end
        default: begin
          p_state_d = P_IDLE;
          case (i_rx_data)
            8'h41:   begin move_vld = 1'b1; move_code = MV_U; end
            8'h42:   begin move_vld = 1'b1; move_code = MV_D; end
            8'h43:   begin move_vld = 1'b1; move_code = MV_R; end
            8'h44:   begin move_vld = 1'b1; move_code = MV_L; end
            default: dec_err = 1'b1;
          endcase
        end
      endcase
    end else if (p_state_q != P_IDLE) begin
      if (esc_cnt_q == ESC_W'(ESC_TMO - 1)) begin
        p_state_d = P_IDLE;
        esc_cnt_d = '0;
      end else begin
        esc_cnt_d = esc_cnt_q + 1'b1;
      end
    end
  end

  // Issuer: one move in flight; ack is ignored during the pulse cycle itself
  always_comb begin
    i_state_d = i_state_q;
    ack_cnt_d = ack_cnt_q;
    pop       = 1'b0;
    ack_tmo   = 1'b0;
    if (new_game) begin
      i_state_d = I_READY;
      ack_cnt_d = '0;
    end else if (i_state_q == I_READY) begin
      if (count_q != '0) begin
        pop       = 1'b1;
        i_state_d = I_WAIT;
        ack_cnt_d = '0;
      end
    end else if (!valid_q) begin
      if (i_ack) begin
        i_state_d = I_READY;
      end else if (ack_cnt_q == ACK_W'(ACK_TMO - 1)) begin
        i_state_d = I_READY;
        ack_tmo   = 1'b1;
      end else begin
        ack_cnt_d = ack_cnt_q + 1'b1;
      end
    end
  end

  // Move FIFO; fullness is judged after this cycle's pop
  always_comb begin
    mem_d           = mem_q;
    rd_ptr_d        = rd_ptr_q;
    wr_ptr_d        = wr_ptr_q;
    count_after_pop = count_q - CNT_W'(pop);
    push            = move_vld && (count_after_pop < CNT_W'(FIFO_DEPTH));
    overflow        = move_vld && !push;
    count_d         = count_after_pop + CNT_W'(push);
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (push) begin
      mem_d[wr_ptr_q] = move_code;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (new_game) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_comb begin
    btn_d      = 4'b0000;
    valid_d    = pop;
    new_game_d = new_game;
    err_d      = dec_err | overflow | ack_tmo;
    if (pop) begin
      case (mem_q[rd_ptr_q])
        MV_L:    btn_d = 4'b1000;
        MV_R:    btn_d = 4'b0100;
        MV_U:    btn_d = 4'b0010;
        default: btn_d = 4'b0001;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_state_q  <= P_IDLE;
      esc_cnt_q  <= '0;
      i_state_q  <= I_READY;
      ack_cnt_q  <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= MV_L;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      btn_q      <= 4'b0000;
      valid_q    <= 1'b0;
      new_game_q <= 1'b0;
      diff_q     <= 2'b00;
      err_q      <= 1'b0;
    end else begin
      p_state_q  <= p_state_d;
      esc_cnt_q  <= esc_cnt_d;
      i_state_q  <= i_state_d;
      ack_cnt_q  <= ack_cnt_d;
      mem_q      <= mem_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      btn_q      <= btn_d;
      valid_q    <= valid_d;
      new_game_q <= new_game_d;
      diff_q     <= diff_d;
      err_q      <= err_d;
    end
  end

  assign o_btnL     = btn_q[3];
  assign o_btnR     = btn_q[2];
  assign o_btnU     = btn_q[1];
  assign o_btnD     = btn_q[0];
  assign o_valid    = valid_q;
  assign o_new_game = new_game_q;
  assign o_diff     = diff_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Randomized + directed bench for uart_cmd_decoder against a queue-based
// reference model evaluated once per clock cycle.
module tb_uart_cmd_decoder;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned ESC_TMO    = 16;
  localparam int unsigned ACK_TMO    = 40;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] i_rx_data;
  logic       i_rx_valid;
  logic       i_ack;
  logic       o_btnL, o_btnR, o_btnU, o_btnD, o_valid, o_new_game, o_err;
  logic [1:0] o_diff;

  uart_cmd_decoder #(
    .FIFO_DEPTH(FIFO_DEPTH), .ESC_TMO(ESC_TMO), .ACK_TMO(ACK_TMO)
  ) dut (
    .clk(clk), .rst(rst), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .i_ack(i_ack), .o_btnL(o_btnL), .o_btnR(o_btnR), .o_btnU(o_btnU),
    .o_btnD(o_btnD), .o_valid(o_valid), .o_new_game(o_new_game),
    .o_diff(o_diff), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: parser mode, move queue, in-flight move timestamps
  int         mode;          // 0 idle, 1 after ESC, 2 after ESC '['
  int         last_byte;
  int         q[$];
  bit         waiting;
  int         pulse_c;
  logic [1:0] m_diff;
  logic [8:0] exp_outs;      // {L,R,U,D,valid,new_game,diff[1:0],err}
  int         cyc = 0;

  function automatic logic [8:0] dut_outs();
    return {o_btnL, o_btnR, o_btnU, o_btnD, o_valid, o_new_game, o_diff, o_err};
  endfunction

  task automatic model_reset();
    mode = 0; last_byte = 0; q.delete(); waiting = 0; pulse_c = 0;
    m_diff = 2'b00; exp_outs = '0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] d, input logic a);
    int mv; bit ng, err, wait_now; logic [3:0] btn; bit vld;
    mv = -1; ng = 0; err = 0; btn = 4'b0000; vld = 0;
    if (v) begin
      if (mode == 0) begin
        case (d)
          "w", "W", "k": mv = 2;
          "s", "S", "j": mv = 3;
          "a", "A", "h": mv = 0;
          "d", "D", "l": mv = 1;
          "n", "N": ng = 1;
          "0", "1", "2", "3": m_diff = d[1:0];
          8'h1B: mode = 1;
          8'h0D, 8'h0A, " ": ;
          default: err = 1;
        endcase
      end else if (mode == 1) begin
        if (d == "[") mode = 2;
        else if (d != 8'h1B) begin mode = 0; err = 1; end
      end else begin
        mode = 0;
        case (d)
          "A": mv = 2;
          "B": mv = 3;
          "C": mv = 1;
          "D": mv = 0;
          default: err = 1;
        endcase
      end
      last_byte = cyc;
    end else if (mode != 0 && cyc - last_byte >= int'(ESC_TMO)) begin
      mode = 0;
    end
    if (ng) begin
      q.delete();
      waiting = 0;
    end else begin
      wait_now = waiting;
      if (waiting && cyc != pulse_c) begin
        if (a) waiting = 0;
        else if (cyc - pulse_c >= int'(ACK_TMO)) begin waiting = 0; err = 1; end
      end
      if (!wait_now && q.size() > 0) begin
        btn = 4'b1000 >> q.pop_front();
        vld = 1; waiting = 1; pulse_c = cyc + 1;
      end
    end
    if (mv >= 0) begin
      if (q.size() < int'(FIFO_DEPTH)) q.push_back(mv);
      else err = 1;
    end
    exp_outs = {btn, vld, ng, m_diff, err};
  endtask

  // One clock cycle: compare the current outputs, drive inputs, advance model
  task automatic cycle(input logic v, input logic [7:0] d, input logic a);
    check("outs", 32'(dut_outs()), 32'(exp_outs));
    i_rx_valid = v; i_rx_data = d; i_ack = a;
    model_step(v, d, a);
    cyc++;
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic a);
    cycle(1'b1, b, a);
  endtask

  task automatic idle(input int n, input logic a);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, a);
  endtask

  task automatic do_reset();
    rst = 1'b1; i_rx_valid = 1'b0; i_rx_data = 8'h00; i_ack = 1'b0;
    #1;
    check("rst_async", 32'(dut_outs()), 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_hold", 32'(dut_outs()), 32'd0);
    rst = 1'b0;
  endtask

  logic [7:0] pool [20] = '{"w", "a", "s", "d", "h", "j", "k", "l", "n", "N",
                            "0", "3", 8'h1B, "[", "A", "B", "C", "D", " ", "x"};

  initial begin
    rst = 1'b1; i_rx_valid = 1'b0; i_rx_data = 8'h00; i_ack = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // single move, then ack timeout
    send("w", 1'b0);
    idle(ACK_TMO + 5, 1'b0);
    // arrow sequence, then lone ESC that times out
    send(8'h1B, 1'b0); send(8'h5B, 1'b0); send(8'h43, 1'b0);
    idle(4, 1'b1);
    send(8'h1B, 1'b1);
    idle(ESC_TMO + 1, 1'b1);
    send("a", 1'b0);
    idle(3, 1'b1);
    // fill the FIFO behind an in-flight move, overflow, then ack one by one
    send("w", 1'b0); send("d", 1'b0); send("s", 1'b0); send("a", 1'b0);
    send("w", 1'b0); send("h", 1'b0);
    idle(3, 1'b0);
    for (int i = 0; i < 5; i++) begin idle(1, 1'b1); idle(3, 1'b0); end
    // new game flushes queued moves
    send("w", 1'b0); send("a", 1'b0); send("s", 1'b0); send("d", 1'b0);
    send("N", 1'b1);
    idle(8, 1'b1);
    // difficulty, bad byte, bad CSI
    send("2", 1'b0); send("x", 1'b0);
    send(8'h1B, 1'b0); send("[", 1'b0); send("Z", 1'b0);
    send("l", 1'b0);
    idle(4, 1'b1);
    // reset in the middle of a wait with moves queued
    send("1", 1'b0); send("k", 1'b0); send("j", 1'b0); send("h", 1'b0);
    idle(3, 1'b0);
    do_reset();
    idle(ACK_TMO + 5, 1'b1);

    // randomized traffic in phases of varying ack willingness
    for (int ph = 0; ph < 40; ph++) begin
      int ack_pct;
      ack_pct = (ph % 4 == 0) ? 0 : int'($urandom_range(5, 60));
      for (int i = 0; i < 80; i++) begin
        logic v, a; logic [7:0] d;
        v = ($urandom_range(0, 2) == 0);
        d = ($urandom_range(0, 9) < 8) ? pool[$urandom_range(0, 19)] : 8'($urandom);
        a = (int'($urandom_range(0, 99)) < ack_pct);
        cycle(v, d, a);
        if ($urandom_range(0, 120) == 0) idle(int'(ESC_TMO) - 1 + int'($urandom_range(0, 3)), a);
      end
    end
    idle(2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
